// File: rtl/microgreen_pkg.sv
// Shared definitions for the microgreen harvest detector.
// Holds the alarm FSM state encoding and the default timing constants
// for a 25 MHz system clock.
package microgreen_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,  // not ready, silent
    ST_ALERT = 2'd1,  // ready, beep pattern running
    ST_QUIET = 2'd2   // ready, silenced (acked or pattern finished)
  } alarm_state_e;

  localparam int DEF_WINDOW       = 8;
  localparam int DEF_ON_THRESH    = 6;
  localparam int DEF_OFF_THRESH   = 2;
  localparam int DEF_BEEP_ON_CYC  = 12_500_000;  // 0.5 s
  localparam int DEF_BEEP_OFF_CYC = 12_500_000;  // 0.5 s
  localparam int DEF_BEEP_COUNT   = 3;
  localparam int DEF_STALE_CYC    = 25_000_000;  // 1 s

endpackage

// File: rtl/vote_window.sv
// Sliding vote window over the last WINDOW prediction bits.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   shift_en     accept bit_in into the window this cycle
//   bit_in       prediction bit to shift in
//   clear        empty the window (history, count, frames seen)
//   vote_count   ones currently in the window
//   window_full  WINDOW frames have been seen since last clear
//   count_nxt    vote count after this edge (for same-edge decisions)
//   full_nxt     window_full after this edge
module vote_window #(
  parameter int WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       bit_in,
  input  logic       clear,
  output logic [4:0] vote_count,
  output logic       window_full,
  output logic [4:0] count_nxt,
  output logic       full_nxt
);

  localparam int FW = $clog2(WINDOW + 1);

  logic [WINDOW-1:0] hist_q, hist_nxt;
  logic [FW-1:0]     frames_q, frames_nxt;
  logic [4:0]        count_q;

  assign window_full = (frames_q == FW'(WINDOW));
  assign vote_count  = count_q;
  assign full_nxt    = (frames_nxt == FW'(WINDOW));

  always_comb begin
    hist_nxt   = hist_q;
    frames_nxt = frames_q;
    count_nxt  = count_q;
    if (clear) begin
      hist_nxt   = '0;
      frames_nxt = '0;
      count_nxt  = '0;
    end else if (shift_en) begin
      hist_nxt = {hist_q[WINDOW-2:0], bit_in};
      // The oldest bit only leaves the count once the window is full;
      // before that it is a slot that never held a frame.
      count_nxt = count_q + 5'(bit_in)
                - (window_full ? 5'(hist_q[WINDOW-1]) : 5'd0);
      if (!window_full) frames_nxt = frames_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q   <= '0;
      frames_q <= '0;
      count_q  <= '0;
    end else begin
      hist_q   <= hist_nxt;
      frames_q <= frames_nxt;
      count_q  <= count_nxt;
    end
  end

endmodule

// File: rtl/harvest_vote_alarm.sv
// Harvest alarm: majority vote with hysteresis over recent BNN inference
// results, a bounded buzzer beep pattern with user acknowledge, and a
// stale-input detector for when inferences stop arriving.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   ena            global enable; when low everything holds, buzzer off
//   result_valid   one-cycle pulse per completed inference
//   result_pred    prediction bit, sampled with result_valid
//   ack            debounced silence button (level; rising edge acts)
//   harvest_ready  hysteresis-filtered harvest flag
//   buzzer         beep drive
//   stale          no inference for STALE_CYC cycles
//   vote_count     ones in the current window
//   window_full    WINDOW frames seen
// Handshake: result_valid is a strobe with no back-pressure; every pulse
// seen while ena=1 is accepted on that clock edge.
module harvest_vote_alarm
  import microgreen_pkg::*;
#(
  parameter int WINDOW       = DEF_WINDOW,
  parameter int ON_THRESH    = DEF_ON_THRESH,
  parameter int OFF_THRESH   = DEF_OFF_THRESH,
  parameter int BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
  parameter int BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
  parameter int BEEP_COUNT   = DEF_BEEP_COUNT,
  parameter int STALE_CYC    = DEF_STALE_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       result_valid,
  input  logic       result_pred,
  input  logic       ack,
  output logic       harvest_ready,
  output logic       buzzer,
  output logic       stale,
  output logic [4:0] vote_count,
  output logic       window_full
);

  localparam int SW   = $clog2(STALE_CYC + 1);
  localparam int BMAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int NW   = $clog2(BEEP_COUNT + 1);

  alarm_state_e  state_q, state_d;
  logic          seq_on_q, seq_on_d;      // beep phase: 1 = ON, 0 = OFF
  logic [BW-1:0] seq_cnt_q, seq_cnt_d;    // cycles spent in current phase
  logic [NW-1:0] beep_num_q, beep_num_d;  // current beep, 1-based
  logic [SW-1:0] stale_cnt_q;
  logic          stale_q;
  logic          ack_q;

  logic          accept, expire, ack_rise;
  logic [4:0]    count_nxt;
  logic          full_nxt;

  assign accept   = ena & result_valid;
  // Expiry fires on the edge the counter would reach STALE_CYC; a valid in
  // that same cycle wins and restarts the count instead.
  assign expire   = ena & ~result_valid & (stale_cnt_q == SW'(STALE_CYC - 1));
  assign ack_rise = ack & ~ack_q;

  vote_window #(.WINDOW(WINDOW)) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en    (accept),
    .bit_in      (result_pred),
    .clear       (expire),
    .vote_count  (vote_count),
    .window_full (window_full),
    .count_nxt   (count_nxt),
    .full_nxt    (full_nxt)
  );

  always_comb begin
    state_d    = state_q;
    seq_on_d   = seq_on_q;
    seq_cnt_d  = seq_cnt_q;
    beep_num_d = beep_num_q;
    if (ena) begin
      if (expire) begin
        state_d = ST_WAIT;
      end else begin
        case (state_q)
          ST_WAIT: begin
            if (full_nxt && (count_nxt >= 5'(ON_THRESH))) begin
              state_d    = ST_ALERT;
              seq_on_d   = 1'b1;
              seq_cnt_d  = '0;
              beep_num_d = NW'(1);
            end
          end
          ST_ALERT: begin
            if (count_nxt <= 5'(OFF_THRESH)) begin
              state_d = ST_WAIT;
            end else if (ack_rise) begin
              state_d = ST_QUIET;
            end else if (seq_on_q) begin
              if (seq_cnt_q == BW'(BEEP_ON_CYC - 1)) begin
                // Last beep goes straight to QUIET, no trailing gap.
                if (beep_num_q == NW'(BEEP_COUNT)) begin
                  state_d = ST_QUIET;
                end else begin
                  seq_on_d  = 1'b0;
                  seq_cnt_d = '0;
                end
              end else begin
                seq_cnt_d = seq_cnt_q + BW'(1);
              end
            end else begin
              if (seq_cnt_q == BW'(BEEP_OFF_CYC - 1)) begin
                seq_on_d   = 1'b1;
                seq_cnt_d  = '0;
                beep_num_d = beep_num_q + NW'(1);
              end else begin
                seq_cnt_d = seq_cnt_q + BW'(1);
              end
            end
          end
          ST_QUIET: begin
            if (count_nxt <= 5'(OFF_THRESH)) state_d = ST_WAIT;
          end
          default: state_d = ST_WAIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      seq_on_q    <= 1'b0;
      seq_cnt_q   <= '0;
      beep_num_q  <= '0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_on_q   <= seq_on_d;
      seq_cnt_q  <= seq_cnt_d;
      beep_num_q <= beep_num_d;
      if (ena) begin
        ack_q <= ack;
        if (result_valid) begin
          stale_cnt_q <= '0;
          stale_q     <= 1'b0;
        end else begin
          if (stale_cnt_q != SW'(STALE_CYC)) stale_cnt_q <= stale_cnt_q + SW'(1);
          if (expire) stale_q <= 1'b1;
        end
      end
    end
  end

  assign harvest_ready = (state_q != ST_WAIT);
  assign buzzer        = ena & (state_q == ST_ALERT) & seq_on_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_harvest_vote_alarm.sv
// Directed bench for harvest_vote_alarm with small timing parameters.
module tb_harvest_vote_alarm;
  import microgreen_pkg::*;

  localparam int WIN   = 8;
  localparam int ON_T  = 6;
  localparam int OFF_T = 2;
  localparam int B_ON  = 4;
  localparam int B_OFF = 4;
  localparam int B_N   = 3;
  localparam int STALE = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, result_valid, result_pred, ack;
  logic       harvest_ready, buzzer, stale, window_full;
  logic [4:0] vote_count;

  harvest_vote_alarm #(
    .WINDOW(WIN), .ON_THRESH(ON_T), .OFF_THRESH(OFF_T),
    .BEEP_ON_CYC(B_ON), .BEEP_OFF_CYC(B_OFF), .BEEP_COUNT(B_N),
    .STALE_CYC(STALE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .result_valid(result_valid), .result_pred(result_pred), .ack(ack),
    .harvest_ready(harvest_ready), .buzzer(buzzer), .stale(stale),
    .vote_count(vote_count), .window_full(window_full)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the vote window and hysteresis
  bit m_hist[$];
  bit m_ready = 1'b0;
  int m_count = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic model_push(input bit p);
    m_hist.push_back(p);
    if (m_hist.size() > WIN) void'(m_hist.pop_front());
    m_count = 0;
    foreach (m_hist[i]) m_count += int'(m_hist[i]);
    if (!m_ready && m_hist.size() == WIN && m_count >= ON_T) m_ready = 1'b1;
    else if (m_ready && m_count <= OFF_T) m_ready = 1'b0;
  endtask

  function automatic logic beep_exp(input int k);
    return (k < B_N * (B_ON + B_OFF) - B_OFF) && ((k % (B_ON + B_OFF)) < B_ON);
  endfunction

  // ---------------- driver ----------------
  task automatic pulse(input logic p);
    model_push(p);
    expect_val(8'(m_count));
    expect_val(8'(m_hist.size() == WIN));
    expect_val(8'(m_ready));
    expect_val(8'd0);
    result_valid = 1'b1;
    result_pred  = p;
    tick();
    result_valid = 1'b0;
    check("vote_count", 8'(vote_count));
    check("window_full", 8'(window_full));
    check("harvest_ready", 8'(harvest_ready));
    check("stale_after_valid", 8'(stale));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; ena = 1'b0; result_valid = 1'b0; result_pred = 1'b0; ack = 1'b0;

    // reset held with toggling inputs
    for (int i = 0; i < 3; i++) begin
      ena          = 1'($urandom_range(0, 1));
      result_valid = 1'($urandom_range(0, 1));
      result_pred  = 1'($urandom_range(0, 1));
      ack          = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i < 5; i++) expect_val(8'd0);
    check("rst_vote_count", 8'(vote_count));
    check("rst_ready", 8'(harvest_ready));
    check("rst_buzzer", 8'(buzzer));
    check("rst_stale", 8'(stale));
    check("rst_full", 8'(window_full));
    rst_n = 1'b1; ena = 1'b1; result_valid = 1'b0; result_pred = 1'b0; ack = 1'b0;

    // eight ones, 5 cycles apart, then full beep pattern
    for (int i = 1; i <= WIN; i++) begin
      pulse(1'b1);
      if (i < WIN) repeat (4) tick();
    end
    for (int k = 0; k < 28; k++) begin
      expect_val(8'(beep_exp(k)));
      check("buzzer_pattern", 8'(buzzer));
      tick();
    end
    expect_val(8'(ST_QUIET));
    check("state_after_pattern", 8'(dut.state_q));

    // zeros: ready holds down to count 3, drops at 2
    for (int j = 0; j < 6; j++) begin
      pulse(1'b0);
      tick();
    end
    expect_val(8'(ST_WAIT));
    check("state_after_drop", 8'(dut.state_q));

    // re-enter ALERT, ack during second beep ON
    for (int j = 0; j < 6; j++) begin
      pulse(1'b1);
      if (j < 5) tick();
    end
    expect_val(8'd1);
    check("buzzer_alert_entry", 8'(buzzer));
    repeat (9) tick();
    expect_val(8'd1);
    check("buzzer_beep2_on", 8'(buzzer));
    ack = 1'b1;
    tick();
    expect_val(8'd0);
    expect_val(8'd1);
    expect_val(8'(ST_QUIET));
    check("buzzer_after_ack", 8'(buzzer));
    check("ready_after_ack", 8'(harvest_ready));
    check("state_after_ack", 8'(dut.state_q));
    for (int j = 0; j < 10; j++) begin
      tick();
      expect_val(8'd0);
      check("buzzer_ack_held", 8'(buzzer));
    end
    ack = 1'b0;

    // stale expiry
    pulse(1'b1);
    repeat (STALE - 1) tick();
    expect_val(8'd0);
    check("stale_before_expiry", 8'(stale));
    tick();
    expect_val(8'd1);
    expect_val(8'd0);
    expect_val(8'd0);
    expect_val(8'd0);
    expect_val(8'd0);
    check("stale_at_expiry", 8'(stale));
    check("vote_count_stale", 8'(vote_count));
    check("full_stale", 8'(window_full));
    check("ready_stale", 8'(harvest_ready));
    check("buzzer_stale", 8'(buzzer));
    m_hist.delete();
    m_ready = 1'b0;
    pulse(1'b1);

    // valid exactly on the expiry cycle keeps history
    repeat (STALE - 1) tick();
    pulse(1'b1);
    tick();
    expect_val(8'd0);
    check("stale_after_near_expiry", 8'(stale));

    // fill window to enter ALERT, then freeze with ena=0
    for (int j = 0; j < 6; j++) begin
      tick();
      pulse(1'b1);
    end
    expect_val(8'd1);
    check("buzzer_alert2_entry", 8'(buzzer));
    tick();
    tick();
    expect_val(8'd1);
    check("buzzer_k2", 8'(buzzer));
    ena = 1'b0;
    result_valid = 1'b1;
    result_pred  = 1'b0;
    tick();
    result_valid = 1'b0;
    expect_val(8'd0);
    expect_val(8'(m_count));
    expect_val(8'd1);
    check("buzzer_ena_off", 8'(buzzer));
    check("vote_count_ena_off", 8'(vote_count));
    check("ready_ena_off", 8'(harvest_ready));
    for (int j = 0; j < 4; j++) begin
      tick();
      expect_val(8'd0);
      check("buzzer_ena_off_hold", 8'(buzzer));
    end
    ena = 1'b1;
    for (int k = 3; k < 24; k++) begin
      tick();
      expect_val(8'(beep_exp(k)));
      check("buzzer_resume", 8'(buzzer));
    end
    expect_val(8'(ST_QUIET));
    check("state_after_resume", 8'(dut.state_q));

    // reset while ready
    rst_n = 1'b0;
    tick();
    expect_val(8'd0);
    expect_val(8'd0);
    expect_val(8'd0);
    check("ready_after_reset", 8'(harvest_ready));
    check("buzzer_after_reset", 8'(buzzer));
    check("vote_count_after_reset", 8'(vote_count));
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
